// File: rtl/dram_mon_agent_pkg.sv
// Shared types and helpers for the DRAM write-side joiner:
// back-pressure modes, LFSR seeds, header and response entries.
package dram_mon_agent_pkg;

   localparam int unsigned HDR_ADDR_W = 64;
   localparam int unsigned HDR_ID_W   = 4;
   localparam int unsigned CNT_W      = 16;

   localparam logic [CNT_W-1:0] REQ_SEED  = 16'hACE1;
   localparam logic [CNT_W-1:0] DATA_SEED = 16'h1D2B;

   typedef enum logic [1:0] {
      BP_NEVER  = 2'd0,
      BP_LIGHT  = 2'd1,
      BP_MEDIUM = 2'd2,
      BP_HEAVY  = 2'd3
   } bp_t;

   typedef struct packed {
      logic [HDR_ADDR_W-1:0] addr;
      logic [HDR_ID_W-1:0]   id;
   } hdr_t;

   typedef struct packed {
      logic [HDR_ID_W-1:0] id;
      logic [CNT_W-1:0]    due;
   } rsp_t;

   // x^16 + x^14 + x^13 + x^11 + 1, maximal length
   function automatic logic [CNT_W-1:0] lfsr_next(
      input logic [CNT_W-1:0] cur
   );
      logic fb;
      fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
      return {cur[14:0], fb};
   endfunction

   function automatic logic bp_allow(
      input bp_t              mode,
      input logic [CNT_W-1:0] cur
   );
      logic allow;
      allow = 1'b1;
      unique case (mode)
         BP_NEVER:  allow = 1'b1;
         BP_LIGHT:  allow = (cur[1:0] != 2'b10);
         BP_MEDIUM: allow = (cur[3:0] < 4'd6);
         BP_HEAVY:  allow = (cur[3:0] < 4'd3);
         default:   allow = 1'b1;
      endcase
      return allow;
   endfunction

endpackage

// File: rtl/dram_sync_fifo.sv
// Synchronous FIFO with full/empty/count; a pop on a full FIFO
// frees the slot written by a same-cycle push.
module dram_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_o == CW'(DEPTH));
   assign empty_o = (count_o == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | pop_i);
   assign rdata_o = mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_o <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_o <= count_o + 1'b1;
            2'b01:   count_o <= count_o - 1'b1;
            default: count_o <= count_o;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= wdata_i;
   end

endmodule

// File: rtl/dram_mem_write_joiner.sv
// Joins HPDcache write header and data channels into one beat stream
// with randomized input back-pressure and delayed write responses.
module dram_mem_write_joiner
   import dram_mon_agent_pkg::*;
#(
   parameter int unsigned ADDR_W    = HDR_ADDR_W,
   parameter int unsigned ID_W      = HDR_ID_W,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned HDR_DEPTH = 4,
   parameter int unsigned RSP_DEPTH = 8,
   parameter int unsigned RSP_LAT   = 4,
   localparam int unsigned BE_W     = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [ID_W-1:0]   req_id_i,
   input  logic              data_valid_i,
   output logic              data_ready_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic [BE_W-1:0]   be_i,
   input  logic              last_i,
   input  logic [1:0]        req_bp_i,
   input  logic [1:0]        data_bp_i,
   output logic              ext_valid_o,
   input  logic              ext_ready_i,
   output logic [ADDR_W-1:0] ext_addr_o,
   output logic [ID_W-1:0]   ext_id_o,
   output logic [DATA_W-1:0] ext_data_o,
   output logic [BE_W-1:0]   ext_be_o,
   output logic              ext_last_o,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [ID_W-1:0]   rsp_id_o
);

   localparam int unsigned HDR_CW = $clog2(HDR_DEPTH) + 1;
   localparam int unsigned RSP_CW = $clog2(RSP_DEPTH) + 1;

   logic [CNT_W-1:0] req_lfsr;
   logic [CNT_W-1:0] data_lfsr;
   logic [CNT_W-1:0] cycle_cnt;
   logic             allow_req;
   logic             allow_data;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_lfsr   <= REQ_SEED;
         data_lfsr  <= DATA_SEED;
         allow_req  <= 1'b0;
         allow_data <= 1'b0;
         cycle_cnt  <= '0;
      end else begin
         req_lfsr   <= lfsr_next(req_lfsr);
         data_lfsr  <= lfsr_next(data_lfsr);
         allow_req  <= bp_allow(bp_t'(req_bp_i), req_lfsr);
         allow_data <= bp_allow(bp_t'(data_bp_i), data_lfsr);
         cycle_cnt  <= cycle_cnt + 1'b1;
      end
   end

   hdr_t              hdr_in;
   hdr_t              hdr_head;
   logic              hdr_full;
   logic              hdr_empty;
   logic [HDR_CW-1:0] hdr_count;
   logic              req_hs;
   logic              data_hs;
   logic              ext_hs;
   logic              hdr_pop;

   logic              buf_valid;
   logic [ADDR_W-1:0] buf_addr;
   logic [ID_W-1:0]   buf_id;
   logic [DATA_W-1:0] buf_data;
   logic [BE_W-1:0]   buf_be;
   logic              buf_last;

   rsp_t              rsp_in;
   rsp_t              rsp_head;
   logic              rsp_full;
   logic              rsp_empty;
   logic [RSP_CW-1:0] rsp_count;
   logic              rsp_push;
   logic              rsp_pop;
   logic [CNT_W-1:0]  rsp_wait;

   assign hdr_in      = {req_addr_i, req_id_i};
   assign req_ready_o = allow_req & ~hdr_full;
   assign req_hs      = req_valid_i & req_ready_o;
   assign hdr_pop     = data_hs & last_i;

   // A masked last beat still occupies the buffer, so refill
   // is gated on the buffer itself rather than ext_valid_o.
   assign ext_valid_o  = buf_valid & ~(buf_last & rsp_full);
   assign ext_hs       = ext_valid_o & ext_ready_i;
   assign data_ready_o = allow_data & ~hdr_empty & (ext_hs | ~buf_valid);
   assign data_hs      = data_valid_i & data_ready_o;

   dram_sync_fifo #(
      .WIDTH ($bits(hdr_t)),
      .DEPTH (HDR_DEPTH)
   ) u_hdr_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (req_hs),
      .wdata_i (hdr_in),
      .pop_i   (hdr_pop),
      .rdata_o (hdr_head),
      .full_o  (hdr_full),
      .empty_o (hdr_empty),
      .count_o (hdr_count)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         buf_valid <= 1'b0;
         buf_addr  <= '0;
         buf_id    <= '0;
         buf_data  <= '0;
         buf_be    <= '0;
         buf_last  <= 1'b0;
      end else if (data_hs) begin
         buf_valid <= 1'b1;
         buf_addr  <= hdr_head.addr;
         buf_id    <= hdr_head.id;
         buf_data  <= data_i;
         buf_be    <= be_i;
         buf_last  <= last_i;
      end else if (ext_hs) begin
         buf_valid <= 1'b0;
      end
   end

   assign ext_addr_o = buf_addr;
   assign ext_id_o   = buf_id;
   assign ext_data_o = buf_data;
   assign ext_be_o   = buf_be;
   assign ext_last_o = buf_last;

   assign rsp_push = ext_hs & buf_last;
   assign rsp_in   = {buf_id, cycle_cnt + CNT_W'(RSP_LAT)};

   dram_sync_fifo #(
      .WIDTH ($bits(rsp_t)),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (rsp_push),
      .wdata_i (rsp_in),
      .pop_i   (rsp_pop),
      .rdata_o (rsp_head),
      .full_o  (rsp_full),
      .empty_o (rsp_empty),
      .count_o (rsp_count)
   );

   // Wrap-safe: due reached when (cycle_cnt - due) is non-negative
   assign rsp_wait    = cycle_cnt - rsp_head.due;
   assign rsp_valid_o = ~rsp_empty & ~rsp_wait[CNT_W-1];
   assign rsp_pop     = rsp_valid_o & rsp_ready_i;
   assign rsp_id_o    = rsp_head.id;

   logic unused_cnt;
   assign unused_cnt = ^{hdr_count, rsp_count};

endmodule
